// File: rtl/v810_bus_wait_ctl.sv
// v810_bus_wait_ctl
// Wait-state and bus-sizing controller for a V810-style external bus.
// A cycle starts with BCYSTn low (T1). Its wait-state count WS and 16-bit
// flag W16 come from a small configuration table selected by cycle class:
// memory region A[31:30] (entries 0-3), I/O space (entry 4), or acknowledge
// cycles, which are always zero-wait and 32-bit. The data phase (DAn low)
// lasts WS+1 enabled clocks; READYn is pulled low in the last one.
// A data phase may also begin without a T1 (DAn low in IDLE with
// BCYSTn high); the class is then decoded from the live bus signals.
//
// Ports
//   CLK, RESn       clock, asynchronous active-low reset
//   CE              clock enable; nothing advances on an edge with CE=0
//   A, ST, MRQn     address, bus status, memory request (class decode)
//   DAn, BCYSTn     data strobe, bus cycle start
//   READYn, SZRQn   data-phase termination and 16-bit size request
//   BUSY            high while a cycle is in ADDR or DATA
//   CFG_WE/SEL/WD   configuration write port, {W16, WS[2:0]} per entry
//   CFG_RD          combinational read of the selected entry
module v810_bus_wait_ctl (
  input  logic        CLK,
  input  logic        RESn,
  input  logic        CE,
  input  logic [31:0] A,
  input  logic [1:0]  ST,
  input  logic        MRQn,
  input  logic        DAn,
  input  logic        BCYSTn,
  output logic        READYn,
  output logic        SZRQn,
  output logic        BUSY,
  input  logic        CFG_WE,
  input  logic [2:0]  CFG_SEL,
  input  logic [3:0]  CFG_WD,
  output logic [3:0]  CFG_RD
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  logic [1:0] r_state;
  logic [2:0] r_cnt;
  logic       r_w16l;
  logic [3:0] r_cfg [0:4];

  logic [2:0] w_ws;
  logic       w_w16;
  logic       w_dphase;
  logic       w_bypass;
  logic       w_cnt_zero;
  logic       w_unused_addr;

  // Only the region bits of the address take part in decoding.
  assign w_unused_addr = ^A[29:0];

  // Class decode from the live bus signals. I/O wins over acknowledge,
  // which cannot overlap anyway since I/O has ST[0]=0.
  always_comb begin
    w_ws  = 3'd0;
    w_w16 = 1'b0;
    if (MRQn && (ST == 2'b10)) begin
      {w_w16, w_ws} = r_cfg[4];
    end else if (MRQn && ST[0]) begin
      w_ws  = 3'd0;
      w_w16 = 1'b0;
    end else begin
      {w_w16, w_ws} = r_cfg[{1'b0, A[31:30]}];
    end
  end

  // ADDR with DAn low is treated exactly like DATA.
  assign w_dphase   = ((r_state == ST_ADDR) || (r_state == ST_DATA)) && !DAn;
  assign w_bypass   = (r_state == ST_IDLE) && !DAn && BCYSTn;
  assign w_cnt_zero = (r_cnt == 3'd0);

  // A zero-wait bypass cycle terminates in the same clock, straight from
  // the decoded entry, without ever leaving IDLE.
  assign READYn = !((w_dphase && w_cnt_zero) ||
                    (w_bypass && (w_ws == 3'd0)));
  assign SZRQn  = !((w_dphase && w_cnt_zero && r_w16l) ||
                    (w_bypass && (w_ws == 3'd0) && w_w16));
  assign BUSY   = (r_state != ST_IDLE);

  always_comb begin
    CFG_RD = 4'd0;
    if (CFG_SEL <= 3'd4) begin
      CFG_RD = r_cfg[CFG_SEL];
    end
  end

  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) begin
      for (int i = 0; i < 5; i++) begin
        r_cfg[i] <= 4'b0111;
      end
    end else if (CE && CFG_WE && (CFG_SEL <= 3'd4)) begin
      r_cfg[CFG_SEL] <= CFG_WD;
    end
  end

  // BCYSTn is only honoured in IDLE or on the terminating edge; elsewhere
  // it is a protocol error and is ignored. DAn high freezes ADDR/DATA.
  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) begin
      r_state <= ST_IDLE;
      r_cnt   <= 3'd0;
      r_w16l  <= 1'b0;
    end else if (CE) begin
      case (r_state)
        ST_IDLE: begin
          if (!BCYSTn) begin
            r_cnt   <= w_ws;
            r_w16l  <= w_w16;
            r_state <= ST_ADDR;
          end else if (w_bypass && (w_ws != 3'd0)) begin
            // This clock already counts as the first data cycle.
            r_cnt   <= w_ws - 3'd1;
            r_w16l  <= w_w16;
            r_state <= ST_DATA;
          end
        end
        ST_ADDR, ST_DATA: begin
          if (!DAn) begin
            if (w_cnt_zero) begin
              if (!BCYSTn) begin
                r_cnt   <= w_ws;
                r_w16l  <= w_w16;
                r_state <= ST_ADDR;
              end else begin
                r_state <= ST_IDLE;
              end
            end else begin
              r_cnt   <= r_cnt - 3'd1;
              r_state <= ST_DATA;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
